alu_result_sink: RTL and testbench
==================================

// Module: alu_result_sink
// PURPOSE
//   Consumer end of the ALU datapath: accepts {Result, ALUFlags} from the ALU with a
//   per-op condition code and set-flags bit. Evaluates the condition against the stored
//   NZCV register, commits passing results into a small FIFO for downstream readout,
//   and updates NZCV on request. This is the writeback/flags stage fed by the ALU.
// PARAMETERS
//   WIDTH  5  ALU result width, matching the ALU Result bus
//   DEPTH  4  result FIFO entries; a power of two, >= 2
// PORTS
//   clk          in   1      single clock; all state updates on rising edge
//   rst_n        in   1      asynchronous, active-low reset
//   in_valid     in   1      ALU op available
//   in_ready     out  1      sink can accept an op this cycle
//   in_result    in   WIDTH  ALU Result
//   in_flags     in   4      ALU flags {N,Z,C,V}
//   in_cond      in   4      condition code, ARM encoding
//   in_setflags  in   1      1: write in_flags to NZCV if condition passes
//   out_valid    out  1      FIFO head valid
//   out_ready    in   1      downstream pops head
//   out_result   out  WIDTH  FIFO head result
//   out_flags    out  4      flags captured with head result
//   nzcv         out  4      architectural flags register {N,Z,C,V}
//   fifo_count   out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
// BEHAVIOUR
// - Reset (async, rst_n=0): nzcv=0, fifo_count=0, rd/wr pointers=0, out_valid=0,
//   in_ready=1. out_result/out_flags are 0 after reset. Reset mid-operation discards all
//   entries immediately, without waiting for a clock edge.
// - Accept = in_valid & in_ready. in_ready = (fifo_count != DEPTH); no full-bypass.
// - Condition evaluated combinationally on the current (pre-update) nzcv:
//   0000 EQ Z | 0001 NE !Z | 0010 CS C | 0011 CC !C | 0100 MI N | 0101 PL !N
//   0110 VS V | 0111 VC !V | 1000 HI C&!Z | 1001 LS !C|Z | 1010 GE N==V
//   1011 LT N!=V | 1100 GT !Z&(N==V) | 1101 LE Z|(N!=V) | 1110/1111 AL (always)
// - On accept with pass: push {in_result,in_flags}; if in_setflags, nzcv<=in_flags on the
//   same edge.
// - On accept with fail: op is consumed; no push and no nzcv change.
// - Back-to-back ops: op N+1 evaluates against nzcv already updated by op N (1-cycle latency).
// - Output is first-word-fall-through: out_valid = (fifo_count!=0).
//   out_result/out_flags show the head entry while out_valid. Pop = out_valid & out_ready.
// - Push and pop in the same cycle: count unchanged, both pointers advance. This includes
//   count==1. When count==DEPTH, in_ready=0, so no push occurs.
// - Pointers wrap modulo DEPTH. Result data is stored unmodified, with no width change.
// - Two-state flow per side (EMPTY/NONEMPTY, NOTFULL/FULL), derived from fifo_count.
//   No other FSM.
// CONFIGURATION
// - ALU_SINK_STATS_EN defined: adds outputs commit_cnt[7:0] and skip_cnt[7:0].
//   - commit_cnt counts accepted+passed ops; skip_cnt counts accepted+failed ops.
//   - Both saturate at 8'hFF and reset to 0.
// - Undefined: the stats ports and counters do not exist. All other behaviour is identical.
// TESTING
// 1. Reset, then AL op result=5'b01000 flags=0000 setflags=1 -> next cycle
//    out_valid=1, out_result=01000, nzcv=0000, fifo_count=1.
// 2. AL setflags op with flags=0100 (5-5=0) -> nzcv=0100. Then EQ op result=00001
//    -> pushed. Then NE op result=00010 -> dropped, fifo_count unchanged
//    (skip_cnt=1 if stats are enabled).
// 3. out_ready=0, push 4 AL ops (results 1,2,3,4) -> fifo_count=4, in_ready=0, and a
//    5th op stays stalled. Then out_ready=1 -> outputs 1,2,3,4 in order, and in_ready
//    returns to 1 after the first pop.
// 4. With fifo_count=2, push and pop in the same cycle -> fifo_count stays 2, and the
//    next head is the older entry.
// 5. Back-to-back: op A setflags flags=1000 (N), then op B cond MI the next cycle
//    -> B pushed; B with cond PL instead -> dropped.
// 6. With fifo_count=3 and nzcv=0110, drive rst_n=0 between clock edges -> fifo_count=0,
//    out_valid=0, nzcv=0000 immediately. After release, ops are accepted normally.

Source files
------------

// File: rtl/alu_result_sink.sv
// Writeback/flags stage behind the ALU: condition check against NZCV, FWFT result FIFO.
// Define ALU_SINK_STATS_EN to add saturating commit/skip counters.
module alu_result_sink #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_result,
    input  logic [3:0]               in_flags,
    input  logic [3:0]               in_cond,
    input  logic                     in_setflags,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic [3:0]               out_flags,
    output logic [3:0]               nzcv,
    output logic [$clog2(DEPTH):0]   fifo_count
`ifdef ALU_SINK_STATS_EN
    ,
    output logic [7:0]               commit_cnt,
    output logic [7:0]               skip_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = WIDTH + 4;

    typedef enum logic {RD_EMPTY, RD_NONEMPTY} rd_state_e;
    typedef enum logic {WR_NOTFULL, WR_FULL}   wr_state_e;

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    nzcv_q, nzcv_d;

    rd_state_e rd_state;
    wr_state_e wr_state;
    logic      accept, pass, push, pop;

    // ARM condition codes; N=f[3] Z=f[2] C=f[1] V=f[0].
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = !z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = !c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = !n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = !v;
            4'b1000: cond_pass = c & !z;
            4'b1001: cond_pass = !c | z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = !z & (n == v);
            4'b1101: cond_pass = z | (n != v);
            default: cond_pass = 1'b1;
        endcase
    endfunction

    assign rd_state = (count_q == '0) ? RD_EMPTY : RD_NONEMPTY;
    assign wr_state = (count_q == CW'(DEPTH)) ? WR_FULL : WR_NOTFULL;

    assign in_ready   = (wr_state == WR_NOTFULL);
    assign out_valid  = (rd_state == RD_NONEMPTY);
    assign accept     = in_valid & in_ready;
    assign pass       = cond_pass(in_cond, nzcv_q);
    assign push       = accept & pass;
    assign pop        = out_valid & out_ready;

    assign {out_result, out_flags} = mem_q[rd_ptr_q];
    assign nzcv       = nzcv_q;
    assign fifo_count = count_q;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        nzcv_d   = nzcv_q;
        if (push) begin
            mem_d[wr_ptr_q] = {in_result, in_flags};
            wr_ptr_d        = wr_ptr_q + 1'b1;
            if (in_setflags) nzcv_d = in_flags;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        // Simultaneous push/pop leaves occupancy unchanged.
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            nzcv_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            nzcv_q   <= nzcv_d;
        end
    end

`ifdef ALU_SINK_STATS_EN
    logic [7:0] commit_q, commit_d;
    logic [7:0] skip_q, skip_d;

    always_comb begin
        commit_d = commit_q;
        skip_d   = skip_q;
        if (accept && pass && commit_q != 8'hFF)  commit_d = commit_q + 8'd1;
        if (accept && !pass && skip_q != 8'hFF)   skip_d   = skip_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_q <= '0;
            skip_q   <= '0;
        end else begin
            commit_q <= commit_d;
            skip_q   <= skip_d;
        end
    end

    assign commit_cnt = commit_q;
    assign skip_cnt   = skip_q;
`endif

endmodule

// File: tb/tb_alu_result_sink.sv
// Scoreboard bench for alu_result_sink: model NZCV + expected-result queue.
module tb_alu_result_sink;
    localparam int WIDTH = 5;
    localparam int DEPTH = 4;
    localparam logic [3:0] AL = 4'b1110, EQ = 4'b0000, NE = 4'b0001, MI = 4'b0100, PL = 4'b0101;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0, in_ready;
    logic [WIDTH-1:0] in_result = '0;
    logic [3:0]       in_flags = '0, in_cond = '0;
    logic             in_setflags = 1'b0;
    logic             out_valid, out_ready = 1'b0;
    logic [WIDTH-1:0] out_result;
    logic [3:0]       out_flags, nzcv;
    logic [$clog2(DEPTH):0] fifo_count;
`ifdef ALU_SINK_STATS_EN
    logic [7:0] commit_cnt, skip_cnt;
    int m_commit = 0, m_skip = 0;
`endif

    int checks = 0, errors = 0;
    logic [WIDTH+3:0] sb[$];
    logic [3:0] m_nzcv = '0;

    always #5 clk = ~clk;

    alu_result_sink #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_flags(in_flags), .in_cond(in_cond), .in_setflags(in_setflags),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_flags(out_flags), .nzcv(nzcv), .fifo_count(fifo_count)
`ifdef ALU_SINK_STATS_EN
        , .commit_cnt(commit_cnt), .skip_cnt(skip_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Base predicate on cond[3:1]; odd codes invert it, except AL.
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v, p;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0: p = z;
            3'd1: p = cf;
            3'd2: p = n;
            3'd3: p = v;
            3'd4: p = cf && !z;
            3'd5: p = (n == v);
            3'd6: p = !z && (n == v);
            default: return 1'b1;
        endcase
        return c[0] ? !p : p;
    endfunction

    // Inputs are already stable; predict this edge, clock it, check afterwards.
    task automatic step();
        int sz = sb.size();
        chk("out_valid", 32'(out_valid), 32'(sz != 0));
        chk("in_ready", 32'(in_ready), 32'(sz != DEPTH));
        if (out_ready && sz != 0) begin
            chk("pop_data", 32'({out_result, out_flags}), 32'(sb[0]));
            void'(sb.pop_front());
        end
        if (in_valid && sz != DEPTH) begin
            if (cond_ok(in_cond, m_nzcv)) begin
                sb.push_back({in_result, in_flags});
                if (in_setflags) m_nzcv = in_flags;
`ifdef ALU_SINK_STATS_EN
                if (m_commit < 255) m_commit++;
            end else begin
                if (m_skip < 255) m_skip++;
`endif
            end
        end
        @(posedge clk);
        #1;
        chk("count", 32'(fifo_count), 32'(sb.size()));
        chk("nzcv", 32'(nzcv), 32'(m_nzcv));
        if (sb.size() != 0) chk("head", 32'({out_result, out_flags}), 32'(sb[0]));
`ifdef ALU_SINK_STATS_EN
        chk("commit_cnt", 32'(commit_cnt), 32'(m_commit));
        chk("skip_cnt", 32'(skip_cnt), 32'(m_skip));
`endif
    endtask

    task automatic drive(input bit v, input logic [4:0] r, input logic [3:0] f,
                         input logic [3:0] c, input bit sf, input bit rdy);
        in_valid = v; in_result = r; in_flags = f; in_cond = c;
        in_setflags = sf; out_ready = rdy;
        step();
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            drive(0, 0, 0, AL, 0, 1);
            n++;
        end
        chk("drained", 32'(fifo_count), 32'd0);
    endtask

    initial begin
        #1;
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_nzcv", 32'(nzcv), 0);
        chk("rst_data", 32'({out_result, out_flags}), 0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: first AL op appears at the head next cycle
        drive(1, 5'b01000, 4'b0000, AL, 1, 0);
        chk("t1_result", 32'(out_result), 32'b01000);
        chk("t1_valid", 32'(out_valid), 1);
        // 2: Z set, EQ passes, NE dropped
        drive(1, 5'd0, 4'b0100, AL, 1, 0);
        drive(1, 5'b00001, 4'b0000, EQ, 0, 0);
        drive(1, 5'b00010, 4'b0000, NE, 0, 0);
        chk("t2_count", 32'(fifo_count), 3);
        drain();

        // 3: fill, stall a 5th op, then drain in order
        for (int i = 1; i <= 4; i++) drive(1, 5'(i), 4'b0000, AL, 0, 0);
        drive(1, 5'd5, 4'b0000, AL, 0, 0);
        chk("t3_full", 32'(in_ready), 0);
        drive(1, 5'd5, 4'b0000, AL, 0, 1);
        chk("t3_ready_back", 32'(in_ready), 1);
        drive(1, 5'd5, 4'b0000, AL, 0, 1);
        drain();

        // 4: push+pop at count 1 and at count 2
        drive(1, 5'd7, 4'b0001, AL, 0, 0);
        drive(1, 5'd8, 4'b0010, AL, 0, 1);
        drive(1, 5'd9, 4'b0011, AL, 0, 0);
        drive(1, 5'd10, 4'b0000, AL, 0, 1);
        chk("t4_count", 32'(fifo_count), 2);
        drain();

        // 5: back-to-back flag dependency
        drive(1, 5'd11, 4'b1000, AL, 1, 0);
        drive(1, 5'd12, 4'b0000, MI, 0, 0);
        drive(1, 5'd13, 4'b1000, AL, 1, 0);
        drive(1, 5'd14, 4'b0000, PL, 0, 0);
        chk("t5_count", 32'(fifo_count), 3);
        drain();

        // 6: async reset between edges
        for (int i = 0; i < 3; i++) drive(1, 5'(20 + i), 4'b0110, AL, 1, 0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_count", 32'(fifo_count), 0);
        chk("t6_valid", 32'(out_valid), 0);
        chk("t6_nzcv", 32'(nzcv), 0);
        sb.delete();
        m_nzcv = '0;
`ifdef ALU_SINK_STATS_EN
        m_commit = 0; m_skip = 0;
`endif
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1, 5'd30, 4'b0000, AL, 0, 0);
        drive(1, 5'd31, 4'b0000, AL, 0, 1);

        // Random traffic across all condition codes and flag patterns
        repeat (400) drive(1'($urandom_range(0, 3) != 0), 5'($urandom), 4'($urandom),
                           4'($urandom), 1'($urandom), 1'($urandom_range(0, 2) != 0));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
